// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file write side.
//   XLEN     : datapath width
//   REG_W    : register index width
//   NUM_REGS : architectural register count
//   wb_req_t : one buffered write-back request (pc, destination, data, live flag)
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    // 'reg' is a keyword, so the destination field is named regno.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] regno;
        logic [XLEN-1:0]  data;
        logic             live;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of multi-cycle write-back requests.
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_req        : enqueue a request (ignored when full)
//   pop                   : dequeue the head (ignored when empty)
//   kill_en, kill_reg     : clear live on every entry (and on a same-cycle push) targeting kill_reg
//   head                  : current head entry
//   full, empty           : occupancy flags
//   entry_live, entry_reg : per-slot live flags and destinations for pending computation
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wb_req_t                     push_req,
    input  logic                        pop,
    input  logic                        kill_en,
    input  logic [REG_W-1:0]            kill_reg,
    output wb_req_t                     head,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            entry_live,
    output logic [DEPTH-1:0][REG_W-1:0] entry_reg
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A push is allowed into a full buffer only when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].regno == kill_reg) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end

        // Popped slots drop live so that only occupied slots can contribute to pending.
        if (pop_ok) begin
            mem_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d             = rd_ptr_q + AW'(1);
        end

        // Push is applied last: it may reuse the slot just popped.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_req;
            if (kill_en && (push_req.regno == kill_reg)) begin
                mem_d[wr_ptr_q].live = 1'b0;
            end
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        entry_live = '0;
        entry_reg  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i] = mem_q[i].live;
            entry_reg[i]  = mem_q[i].regno;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter. The W-stage always wins; multi-cycle results are buffered
// and drain when the pipeline has no write. A pipeline write kills older buffered writes to
// the same register.
//   clk, reset                             : clock, asynchronous active-high reset
//   pipe_we/pipe_pc/pipe_reg/pipe_data     : W-stage write request
//   mc_valid/mc_ready/mc_pc/mc_reg/mc_data : multi-cycle completion handshake
//   writeEnable/PCReg/writeReg/writeData   : registered register-file write port
//   pending                                : per-register outstanding buffered write (bit 0 tied low)
//   wb_stall_req                           : buffer full, hold W-stage issue
module grf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pipe_we,
    input  logic [XLEN-1:0]     pipe_pc,
    input  logic [REG_W-1:0]    pipe_reg,
    input  logic [XLEN-1:0]     pipe_data,
    input  logic                mc_valid,
    output logic                mc_ready,
    input  logic [XLEN-1:0]     mc_pc,
    input  logic [REG_W-1:0]    mc_reg,
    input  logic [XLEN-1:0]     mc_data,
    output logic                writeEnable,
    output logic [XLEN-1:0]     PCReg,
    output logic [REG_W-1:0]    writeReg,
    output logic [XLEN-1:0]     writeData,
    output logic [NUM_REGS-1:0] pending,
    output logic                wb_stall_req
);

    wb_req_t                     fifo_head;
    wb_req_t                     push_req;
    logic                        fifo_full, fifo_empty;
    logic                        fifo_push, fifo_pop, kill_en;
    logic [DEPTH-1:0]            entry_live;
    logic [DEPTH-1:0][REG_W-1:0] entry_reg;

    logic                we_q, we_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic [XLEN-1:0]     data_q, data_d;

    assign mc_ready     = !fifo_full;
    assign wb_stall_req = fifo_full;

    assign fifo_push = mc_valid && mc_ready;
    // The head drains (live or killed) in any cycle the W-stage is not writing.
    assign fifo_pop  = !pipe_we && !fifo_empty;
    // $0 writes never supersede anything.
    assign kill_en   = pipe_we && (pipe_reg != '0);

    assign push_req = '{pc: mc_pc, regno: mc_reg, data: mc_data, live: 1'b1};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_req  (push_req),
        .pop       (fifo_pop),
        .kill_en   (kill_en),
        .kill_reg  (pipe_reg),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entry_live(entry_live),
        .entry_reg (entry_reg)
    );

    always_comb begin
        we_d   = 1'b0;
        pc_d   = pc_q;
        reg_d  = reg_q;
        data_d = data_q;
        if (pipe_we) begin
            we_d   = 1'b1;
            pc_d   = pipe_pc;
            reg_d  = pipe_reg;
            data_d = pipe_data;
        end else if (!fifo_empty && fifo_head.live) begin
            we_d   = 1'b1;
            pc_d   = fifo_head.pc;
            reg_d  = fifo_head.regno;
            data_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            pc_q   <= '0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            pc_q   <= pc_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign writeEnable = we_q;
    assign PCReg       = pc_q;
    assign writeReg    = reg_q;
    assign writeData   = data_q;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i]) begin
                pending = pending | reg_onehot(entry_reg[i]);
            end
        end
        pending[0] = 1'b0;
    end

endmodule
